// File: rtl/overlay_line_source.sv
// -----------------------------------------------------------------------------
// overlay_line_source
//
// Double-buffered overlay line source. A writer fills one line bank (the fill
// bank) through a valid/ready interface while the other bank (the display
// bank) is read out one pixel per pixel clock during active video. On each
// lineStart a completely written fill bank is swapped into display. If no
// complete line is buffered, the line is shown fully transparent and a sticky
// underflow flag is raised.
//
// Ports
//   pixelClockX6     sole clock (six cycles per pixel)
//   reset            synchronous, active-high reset
//   pixelClockPhase  pixel phase 0..5; phase 0 is the pixel-update cycle
//   lineStart        one-cycle pulse at the start of each display line
//   activeVideo      high during active pixels of a line
//   overlayEnable    low forces transparent output
//   wrValid/wrReady  writer handshake; a pixel is taken when both are high
//   wrData           {red[5:0], green[5:0], blue[5:0]}
//   wrLast           marks the final pixel of the line being written
//   red_fg/green_fg/blue_fg  registered foreground pixel, all-zero = transparent
//   underflow        sticky: a line started with no complete line buffered
// -----------------------------------------------------------------------------
module overlay_line_source #(
    parameter int LINE_PIXELS = 720,
    parameter int ADDR_W      = 10
) (
    input  logic        pixelClockX6,
    input  logic        reset,
    input  logic [2:0]  pixelClockPhase,
    input  logic        lineStart,
    input  logic        activeVideo,
    input  logic        overlayEnable,
    input  logic        wrValid,
    output logic        wrReady,
    input  logic [17:0] wrData,
    input  logic        wrLast,
    output logic [5:0]  red_fg,
    output logic [5:0]  green_fg,
    output logic [5:0]  blue_fg,
    output logic        underflow
);

    // Counters carry one extra bit so they can hold LINE_PIXELS itself even
    // when LINE_PIXELS equals 2^ADDR_W.
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LINE_MAX = CNT_W'(LINE_PIXELS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Line banks; bank_sel_r names the fill bank, the other one is displayed.
    logic [17:0]       bank0_r [LINE_PIXELS];
    logic [17:0]       bank1_r [LINE_PIXELS];

    logic              bank_sel_r;
    logic [CNT_W-1:0]  fill_count_r;
    logic [CNT_W-1:0]  disp_count_r;
    logic [CNT_W-1:0]  read_addr_r;
    logic              full_r;
    logic              wr_ready_r;
    logic              underflow_r;
    logic [17:0]       fg_r;

    logic              wr_accept_s;
    logic              fill_done_s;
    logic              phase0_s;
    logic              pix_valid_s;
    logic [ADDR_W-1:0] rd_idx_s;
    logic [ADDR_W-1:0] wr_idx_s;
    logic [17:0]       rd_data_s;

    // Handshake decode, line-complete detection and display-bank read mux.
    always_comb begin
        wr_accept_s = wrValid && wr_ready_r;
        fill_done_s = wr_accept_s &&
                      (wrLast || ((fill_count_r + CNT_ONE) == LINE_MAX));
        phase0_s    = (pixelClockPhase == 3'd0);
        pix_valid_s = activeVideo && overlayEnable && (read_addr_r < disp_count_r);
        wr_idx_s    = fill_count_r[ADDR_W-1:0];
        // Only index the bank with an in-range address; past the end of the
        // line the data is discarded anyway.
        if (pix_valid_s) begin
            rd_idx_s = read_addr_r[ADDR_W-1:0];
        end else begin
            rd_idx_s = {ADDR_W{1'b0}};
        end
        if (bank_sel_r) begin
            rd_data_s = bank0_r[rd_idx_s];
        end else begin
            rd_data_s = bank1_r[rd_idx_s];
        end
    end

    // Fill-bank write port; memory contents need no reset.
    always_ff @(posedge pixelClockX6) begin
        if (!reset && wr_accept_s) begin
            if (bank_sel_r) begin
                bank1_r[wr_idx_s] <= wrData;
            end else begin
                bank0_r[wr_idx_s] <= wrData;
            end
        end
    end

    // Fill/display bookkeeping, read address and registered pixel output.
    always_ff @(posedge pixelClockX6) begin
        if (reset) begin
            bank_sel_r   <= 1'b0;
            fill_count_r <= {CNT_W{1'b0}};
            disp_count_r <= {CNT_W{1'b0}};
            read_addr_r  <= {CNT_W{1'b0}};
            full_r       <= 1'b0;
            wr_ready_r   <= 1'b1;
            underflow_r  <= 1'b0;
            fg_r         <= 18'h00000;
        end else begin
            // A full bank cannot accept writes, so the swap never collides
            // with an accepted write. A write that completes the line on a
            // lineStart edge is kept, but that line still underflows.
            if (lineStart && full_r) begin
                bank_sel_r   <= ~bank_sel_r;
                disp_count_r <= fill_count_r;
                fill_count_r <= {CNT_W{1'b0}};
                full_r       <= 1'b0;
                wr_ready_r   <= 1'b1;
            end else begin
                if (wr_accept_s) begin
                    fill_count_r <= fill_count_r + CNT_ONE;
                    if (fill_done_s) begin
                        full_r     <= 1'b1;
                        wr_ready_r <= 1'b0;
                    end else begin
                        full_r     <= full_r;
                        wr_ready_r <= wr_ready_r;
                    end
                end else begin
                    fill_count_r <= fill_count_r;
                end
                if (lineStart) begin
                    disp_count_r <= {CNT_W{1'b0}};
                    underflow_r  <= 1'b1;
                end else begin
                    disp_count_r <= disp_count_r;
                end
            end

            // Read address advances on every active pixel, independent of
            // overlayEnable, and parks at LINE_PIXELS.
            if (lineStart) begin
                read_addr_r <= {CNT_W{1'b0}};
            end else if (phase0_s && activeVideo && (read_addr_r < LINE_MAX)) begin
                read_addr_r <= read_addr_r + CNT_ONE;
            end else begin
                read_addr_r <= read_addr_r;
            end

            // Pixel output only changes on pixel-update edges.
            if (phase0_s) begin
                if (pix_valid_s) begin
                    fg_r <= rd_data_s;
                end else begin
                    fg_r <= 18'h00000;
                end
            end else begin
                fg_r <= fg_r;
            end
        end
    end

    assign wrReady   = wr_ready_r;
    assign underflow = underflow_r;
    assign red_fg    = fg_r[17:12];
    assign green_fg  = fg_r[11:6];
    assign blue_fg   = fg_r[5:0];

endmodule

// File: doc/overlay_line_source.md
OVERLAY_LINE_SOURCE -- requirements
Module: overlay_line_source

Interface
REQ-001 Parameter LINE_PIXELS, default 720: maximum pixels per overlay line.
REQ-002 Parameter ADDR_W, default 10: width of the line-buffer address and counters; 2^ADDR_W SHALL be at least LINE_PIXELS.
REQ-003 pixelClockX6  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pixelClockPhase  in  3  pixel phase 0..5; phase 0 is the pixel-update cycle.
REQ-006 lineStart  in  1  one-cycle pulse at the start of each display line.
REQ-007 activeVideo  in  1  high during active pixels of a line.
REQ-008 overlayEnable  in  1  low forces transparent output.
REQ-009 wrValid  in  1  writer presents a pixel.
REQ-010 wrReady  out  1  block can accept a pixel.
REQ-011 wrData  in  18  {red[5:0], green[5:0], blue[5:0]}.
REQ-012 wrLast  in  1  qualifies wrData as the final pixel of the line being written.
REQ-013 red_fg, green_fg, blue_fg  out  6 each  foreground pixel; all-zero means transparent.
REQ-014 underflow  out  1  sticky flag: a line started with no complete line buffered.

Function
REQ-015 The block SHALL hold two LINE_PIXELS x 18 banks: one fill bank and one display bank.
REQ-016 A write SHALL be accepted when wrValid && wrReady; data goes to the fill bank at fillCount, and fillCount increments.
REQ-017 The fill bank SHALL become full on an accepted write with wrLast=1, or on the write that makes fillCount equal LINE_PIXELS.
REQ-018 wrReady SHALL be 0 while the fill bank is full, and 1 otherwise.
REQ-019 On lineStart with the fill bank full (registered flag before this edge), the banks SHALL swap: dispCount becomes fillCount, fillCount becomes 0, full clears, and wrReady is 1 the next cycle.
REQ-020 On lineStart with the fill bank not full, there SHALL be no swap; dispCount becomes 0, so the whole line is transparent, and underflow is set.
REQ-021 A write completing the line on the same cycle as lineStart SHALL be committed, but the swap SHALL wait for the next lineStart (REQ-020 applies this line).
REQ-022 lineStart SHALL reset readAddr to 0.
REQ-023 On each cycle with pixelClockPhase==0 and activeVideo=1, readAddr SHALL advance by 1, saturating at LINE_PIXELS.
REQ-024 Outputs SHALL update only on phase-0 edges.
REQ-025 On a phase-0 edge with activeVideo=1, overlayEnable=1 and readAddr<dispCount, the outputs SHALL equal the display-bank entry at readAddr.
REQ-026 On any other phase-0 edge, the outputs SHALL be 0.
REQ-027 The pixel read from address n SHALL appear on the (n+1)th phase-0 edge of the line, so first-pixel latency is one phase-0 edge.
REQ-028 overlayEnable=0 SHALL NOT stop readAddr advancing or bank swapping.
REQ-029 Written pixel value 0 SHALL be output as 0, i.e. transparent; no substitution.
REQ-030 Writes SHALL NOT disturb the display bank.
REQ-031 underflow SHALL clear only on reset.

Reset
REQ-032 reset=1 SHALL, at the next edge, set: outputs 0, underflow 0, fillCount 0, dispCount 0, readAddr 0, full 0, wrReady 1, bank select 0.
REQ-033 Memory contents need no reset; dispCount=0 guarantees transparent output.
REQ-034 Reset asserted mid-line or mid-write SHALL discard the partial line; the first post-reset lineStart gives underflow unless a complete line was written before it.

Verification
REQ-035 Write 720 pixels of 0x3F000 (red) without wrLast, then lineStart, then 720 active phase-0 pixels -> wrReady=0 after write 720; red_fg=63, green_fg=0, blue_fg=0 for all 720 pixels; underflow=0.
REQ-036 Write 3 pixels {0x00001, 0x00002, 0x00003}, wrLast on the 3rd, then lineStart, then active line -> blue_fg sequence 1, 2, 3, then 0 for the remaining 717 pixels.
REQ-037 lineStart with nothing written -> all outputs 0 for the line; underflow=1 and stays 1 across later good lines until reset.
REQ-038 wrLast accepted on the same cycle as lineStart -> that line is transparent with underflow=1; the next lineStart displays the written line.
REQ-039 Full line buffered, overlayEnable=0 -> outputs 0 and readAddr reaches 720; with overlayEnable=1 on the next line, data from the following buffered line appears.
REQ-040 reset pulse after 100 pixels are written -> wrReady=1 and fillCount=0; the next lineStart gives transparent output and underflow=1.
